// File: rtl/text_vram_pkg.sv
// rtl/text_vram_pkg.sv - shared constants, state encoding and window decode for text_vram
package text_vram_pkg;

    // Byte-address text window seen by the FML (video fetch) port.
    localparam logic [31:0] win_base   = 32'h000B_8000;
    localparam logic [31:0] win_size   = 32'h0000_8000;

    // Returned for reads outside the window: space character, light grey on black.
    localparam logic [15:0] blank_word = 16'h0720;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FML_RD  = 3'd1,
        S_FML_ACK = 3'd2,
        S_WB_RD   = 3'd3,
        S_WB_ACK  = 3'd4
    } vram_state_t;

    function automatic logic in_window(input logic [31:0] byte_adr);
        return (byte_adr >= win_base) && (byte_adr < (win_base + win_size));
    endfunction

endpackage

// File: rtl/vram_sp.sv
// rtl/vram_sp.sv - single-port byte-enabled RAM with synchronous read
// Ports: clk; en (access this cycle); we (write, else read); be (byte enables);
//        addr (word address); wdata (write word); rdata (read word, valid the cycle after a read).
module vram_sp #(
    parameter int vram_aw = 12
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [1:0]         be,
    input  logic [vram_aw-1:0] addr,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata
);

    logic [15:0] mem [0:(1<<vram_aw)-1];

    // Contents are deliberately not reset so screen data survives a controller reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                if (be[0]) mem[addr][7:0]  <= wdata[7:0];
                if (be[1]) mem[addr][15:8] <= wdata[15:8];
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/text_vram.sv
// rtl/text_vram.sv - text-mode video RAM shared between an FML read port and a Wishbone slave
// Ports: clk; rst (async, active-low);
//        fml_adr/fml_stb -> fml_ack/fml_do : video fetch reads of {attr, char} words;
//        wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_stb_i/wb_cyc_i -> wb_ack_o/wb_dat_o : CPU access.
module text_vram
    import text_vram_pkg::*;
#(
    parameter int fml_depth = 25,
    parameter int vram_aw   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [fml_depth-1:0] fml_adr,
    input  logic                 fml_stb,
    output logic                 fml_ack,
    output logic [15:0]          fml_do,
    input  logic [15:1]          wb_adr_i,
    input  logic [15:0]          wb_dat_i,
    output logic [15:0]          wb_dat_o,
    input  logic [1:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    output logic                 wb_ack_o
);

    vram_state_t        state;
    vram_state_t        state_d;
    logic               last_fml;   // previous grant went to FML
    logic               fml_miss;   // current FML read is outside the window
    logic               fml_req;
    logic               wb_req;
    logic               fml_hit;
    logic               grant_fml;
    logic               grant_wb;
    logic               ram_en;
    logic               ram_we;
    logic [1:0]         ram_be;
    logic [vram_aw-1:0] ram_addr;
    logic [15:0]        ram_rdata;

    // Word index bits above vram_aw alias; they are intentionally not decoded.
    logic unused_wb_bits;
    assign unused_wb_bits = ^wb_adr_i;

    assign fml_req = fml_stb;
    assign wb_req  = wb_cyc_i & wb_stb_i;
    assign fml_hit = in_window(32'(fml_adr));

    always_comb begin
        state_d   = state;
        grant_fml = 1'b0;
        grant_wb  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 2'b00;
        ram_addr  = '0;
        fml_ack   = 1'b0;
        wb_ack_o  = 1'b0;
        case (state)
            S_IDLE: begin
                // FML normally wins; after an FML grant a waiting CPU gets its turn.
                if (fml_req && !(last_fml && wb_req)) begin
                    grant_fml = 1'b1;
                    ram_en    = fml_hit;
                    ram_addr  = fml_adr[vram_aw:1];
                    state_d   = S_FML_RD;
                end else if (wb_req) begin
                    grant_wb  = 1'b1;
                    ram_en    = 1'b1;
                    ram_we    = wb_we_i;
                    ram_be    = wb_sel_i;
                    ram_addr  = wb_adr_i[vram_aw:1];
                    state_d   = wb_we_i ? S_WB_ACK : S_WB_RD;
                end
            end
            S_FML_RD:  state_d = S_FML_ACK;
            S_FML_ACK: begin
                fml_ack = 1'b1;
                state_d = S_IDLE;
            end
            S_WB_RD:   state_d = S_WB_ACK;
            S_WB_ACK: begin
                wb_ack_o = 1'b1;
                state_d  = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            last_fml <= 1'b0;
            fml_miss <= 1'b0;
            fml_do   <= '0;
            wb_dat_o <= '0;
        end else begin
            state <= state_d;
            if (grant_fml) begin
                last_fml <= 1'b1;
                fml_miss <= !fml_hit;
            end
            if (grant_wb) begin
                last_fml <= 1'b0;
            end
            if (state == S_FML_RD) begin
                fml_do <= fml_miss ? blank_word : ram_rdata;
            end
            if (state == S_WB_RD) begin
                wb_dat_o <= ram_rdata;
            end
        end
    end

    // Gate the RAM while reset is held so a requester parked on a write cannot modify it.
    vram_sp #(
        .vram_aw (vram_aw)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en & rst),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (wb_dat_i),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_text_vram.sv
// tb/tb_text_vram.sv - self-checking bench for text_vram
module tb_text_vram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] fml_adr;
    logic        fml_stb;
    logic        fml_ack;
    logic [15:0] fml_do;
    logic [15:1] wb_adr;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;

    always #5 clk = ~clk;

    text_vram #(.fml_depth(25), .vram_aw(12)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .fml_adr  (fml_adr),
        .fml_stb  (fml_stb),
        .fml_ack  (fml_ack),
        .fml_do   (fml_do),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel),
        .wb_we_i  (wb_we),
        .wb_stb_i (wb_stb),
        .wb_cyc_i (wb_cyc),
        .wb_ack_o (wb_ack)
    );

    int tests = 0;
    int fails = 0;
    int overlaps = 0;

    logic [15:0] model_mem [0:4095];
    bit          last_fml = 1'b0;

    always @(negedge clk) if (fml_ack && wb_ack) overlaps++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model_fml(input logic [24:0] a);
        int ua = int'(a);
        if (ua >= 32'hB8000 && ua < 32'hC0000) return model_mem[(ua / 2) % 4096];
        return 16'h0720;
    endfunction

    task automatic model_write(input logic [14:0] wa, input logic [15:0] d, input logic [1:0] sel);
        int idx = int'(wa) % 4096;
        if (sel[0]) model_mem[idx][7:0]  = d[7:0];
        if (sel[1]) model_mem[idx][15:8] = d[15:8];
    endtask

    task automatic wb_xfer(input logic we, input logic [14:0] wa, input logic [15:0] d,
                           input logic [1:0] sel, output logic [15:0] rd, output int lat);
        @(negedge clk);
        wb_adr = wa; wb_dat_i = d; wb_sel = sel; wb_we = we; wb_stb = 1'b1; wb_cyc = 1'b1;
        lat = -1; rd = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (wb_ack) begin lat = c; rd = wb_dat_o; break; end
        end
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        last_fml = 1'b0;
        if (we) model_write(wa, d, sel);
    endtask

    task automatic fml_read(input logic [24:0] fa, output logic [15:0] rd, output int lat);
        @(negedge clk);
        fml_adr = fa; fml_stb = 1'b1;
        lat = -1; rd = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (fml_ack) begin lat = c; rd = fml_do; break; end
        end
        fml_stb = 1'b0;
        last_fml = 1'b1;
    endtask

    // FML read and WB read raised together; both requesters hold until their own ack.
    task automatic dual(input logic [24:0] fa, input logic [14:0] wa, input string tag);
        int fl = -1, wl = -1;
        logic [15:0] fd = '0, wd = '0;
        bit fml_first = !last_fml;
        @(negedge clk);
        fml_adr = fa; fml_stb = 1'b1;
        wb_adr = wa; wb_we = 1'b0; wb_sel = 2'b11; wb_stb = 1'b1; wb_cyc = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (fml_ack) begin fl = c; fd = fml_do; fml_stb = 1'b0; end
            if (wb_ack)  begin wl = c; wd = wb_dat_o; wb_stb = 1'b0; wb_cyc = 1'b0; end
            if (fl > 0 && wl > 0) break;
        end
        fml_stb = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        check({tag, " fml lat"}, 32'(fl), fml_first ? 32'd2 : 32'd5);
        check({tag, " wb lat"},  32'(wl), fml_first ? 32'd5 : 32'd2);
        check({tag, " fml data"}, {16'h0, fd}, {16'h0, model_fml(fa)});
        check({tag, " wb data"},  {16'h0, wd}, {16'h0, model_mem[int'(wa) % 4096]});
        last_fml = !fml_first;
    endtask

    typedef struct {
        bit          is_fml;
        bit          we;
        logic [24:0] fa;
        logic [14:0] wa;
        logic [15:0] wdat;
        logic [1:0]  sel;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [15:0] rd;
        int lat;
        int seen;

        #2_000_000;
        $display("FAIL global timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        int lat;
        int seen;

        rst_n = 1'b0;
        fml_adr = '0; fml_stb = 1'b0;
        wb_adr = '0; wb_dat_i = '0; wb_sel = 2'b00; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (3) @(negedge clk);
        check("reset fml_ack", {31'h0, fml_ack}, 32'h0);
        check("reset wb_ack",  {31'h0, wb_ack},  32'h0);
        check("reset fml_do",  {16'h0, fml_do},  32'h0);
        check("reset wb_dat_o", {16'h0, wb_dat_o}, 32'h0);
        rst_n = 1'b1;

        //                 fml we  fml_adr       wb_adr    wdata     sel    expect    lat
        vecs.push_back('{1'b0, 1'b1, 25'h0,       15'h0000, 16'h1F41, 2'b11, 16'h0000, 1});
        vecs.push_back('{1'b1, 1'b0, 25'hB8000,   15'h0000, 16'h0000, 2'b00, 16'h1F41, 2});
        vecs.push_back('{1'b0, 1'b1, 25'h0,       15'h0005, 16'h1F41, 2'b11, 16'h0000, 1});
        vecs.push_back('{1'b0, 1'b1, 25'h0,       15'h0005, 16'h0058, 2'b01, 16'h0000, 1});
        vecs.push_back('{1'b1, 1'b0, 25'hB800A,   15'h0000, 16'h0000, 2'b00, 16'h1F58, 2});
        vecs.push_back('{1'b1, 1'b0, 25'h000100,  15'h0000, 16'h0000, 2'b00, 16'h0720, 2});
        vecs.push_back('{1'b1, 1'b0, 25'hBA000,   15'h0000, 16'h0000, 2'b00, 16'h1F41, 2});
        vecs.push_back('{1'b0, 1'b0, 25'h0,       15'h0005, 16'h0000, 2'b00, 16'h1F58, 2});
        vecs.push_back('{1'b0, 1'b1, 25'h0,       15'h0005, 16'hFFFF, 2'b00, 16'h0000, 1});
        vecs.push_back('{1'b0, 1'b0, 25'h0,       15'h1005, 16'h0000, 2'b00, 16'h1F58, 2});
        vecs.push_back('{1'b0, 1'b1, 25'h0,       15'h0FFF, 16'hABCD, 2'b11, 16'h0000, 1});
        vecs.push_back('{1'b0, 1'b1, 25'h0,       15'h0FFF, 16'h3300, 2'b10, 16'h0000, 1});
        vecs.push_back('{1'b1, 1'b0, 25'hBFFFF,   15'h0000, 16'h0000, 2'b00, 16'h33CD, 2});
        vecs.push_back('{1'b1, 1'b0, 25'hC0000,   15'h0000, 16'h0000, 2'b00, 16'h0720, 2});
        vecs.push_back('{1'b1, 1'b0, 25'hB7FFE,   15'h0000, 16'h0000, 2'b00, 16'h0720, 2});

        foreach (vecs[i]) begin
            if (vecs[i].is_fml) begin
                fml_read(vecs[i].fa, rd, lat);
                check($sformatf("vec%0d fml data", i), {16'h0, rd}, {16'h0, vecs[i].exp});
            end else begin
                wb_xfer(vecs[i].we, vecs[i].wa, vecs[i].wdat, vecs[i].sel, rd, lat);
                if (!vecs[i].we)
                    check($sformatf("vec%0d wb data", i), {16'h0, rd}, {16'h0, vecs[i].exp});
            end
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Reset while the FML read sits in FML_RD: no ack, outputs cleared, RAM kept.
        @(negedge clk);
        fml_adr = 25'hB8000; fml_stb = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst fml_do", {16'h0, fml_do}, 32'h0);
        fml_stb = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (fml_ack || wb_ack) seen++;
        end
        check("midrst no ack", 32'(seen), 32'h0);
        rst_n = 1'b1;
        last_fml = 1'b0;
        fml_read(25'hB8000, rd, lat);
        check("postrst fml data", {16'h0, rd}, 32'h1F41);
        check("postrst fml lat", 32'(lat), 32'd2);

        // Reset landing in the write's ack cycle: ack dropped, write retained.
        @(negedge clk);
        wb_adr = 15'h0007; wb_dat_i = 16'h1234; wb_sel = 2'b11; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(negedge clk);
        check("wrrst ack before", {31'h0, wb_ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("wrrst ack cut", {31'h0, wb_ack}, 32'h0);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_fml = 1'b0;
        model_write(15'h0007, 16'h1234, 2'b11);
        wb_xfer(1'b0, 15'h0007, 16'h0, 2'b11, rd, lat);
        check("wrrst retained", {16'h0, rd}, 32'h1234);

        // Arbitration: after a WB grant FML goes first, after an FML grant WB goes first.
        dual(25'hB8000, 15'h0005, "dual_after_wb");
        fml_read(25'hB800A, rd, lat);
        dual(25'hB8000, 15'h0005, "dual_after_fml");

        // Randomized traffic against the array model.
        for (int w = 0; w < 16; w++)
            wb_xfer(1'b1, 15'(w * 37), 16'($urandom), 2'b11, rd, lat);
        for (int n = 0; n < 200; n++) begin
            int op = $urandom_range(0, 4);
            int w = $urandom_range(0, 15) * 37;
            logic [14:0] wa = 15'(($urandom_range(0, 7) << 12) | w);
            logic [24:0] fa = 25'(32'hB8000 + $urandom_range(0, 3) * 32'h2000 + w * 2 + $urandom_range(0, 1));
            case (op)
                0: begin
                    wb_xfer(1'b1, wa, 16'($urandom), 2'($urandom), rd, lat);
                    check($sformatf("rnd%0d wr lat", n), 32'(lat), 32'd1);
                end
                1: begin
                    wb_xfer(1'b0, wa, 16'h0, 2'b11, rd, lat);
                    check($sformatf("rnd%0d wb data", n), {16'h0, rd}, {16'h0, model_mem[w % 4096]});
                    check($sformatf("rnd%0d wb lat", n), 32'(lat), 32'd2);
                end
                2, 3: begin
                    if (op == 3) begin
                        if ($urandom_range(0, 1) != 0) fa = 25'($urandom_range(0, 32'hB7FFF));
                        else fa = 25'($urandom_range(32'hC0000, 32'h1FFFFFF));
                    end
                    fml_read(fa, rd, lat);
                    check($sformatf("rnd%0d fml data", n), {16'h0, rd}, {16'h0, model_fml(fa)});
                    check($sformatf("rnd%0d fml lat", n), 32'(lat), 32'd2);
                end
                default: dual(fa, wa, $sformatf("rnd%0d dual", n));
            endcase
        end

        check("ack overlap count", 32'(overlaps), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
